// File: rtl/dec_sched_pkg.sv
// Shared state encoding and field widths for the decimation-clock configuration scheduler.
package dec_sched_pkg;
  localparam int RATIO_W    = 7;
  localparam int DELAY_W    = 7;
  localparam int EDGE_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DLY,
    SETTLE,
    ACK
  } state_t;
endpackage

// File: rtl/dec_clk_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter: first set request at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int  N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from farthest to nearest so the slot closest to the pointer wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[slot_of(ptr, k)]) begin
        grant_idx = slot_of(ptr, k);
        any       = 1'b1;
      end
    end
    grant = any ? (N_REQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= slot_of(grant_idx, 1);
    end
  end
endmodule

// File: rtl/dec_clk_scheduler.sv
// Arbitrates ratio/delay updates to the decimation divider and acks each requester after
// SETTLE_EDGES dec_clk edges (or timeout). DEC_SCHED_RANGE_CHECK_EN rejects ratios 0/1.
module dec_clk_scheduler
  import dec_sched_pkg::*;
#(
  parameter int                 N_REQ          = 4,
  parameter int                 SETTLE_EDGES   = 2,
  parameter int                 SETTLE_TIMEOUT = 1023,
  parameter logic [RATIO_W-1:0] DEFAULT_RATIO  = 7'd2,
  localparam int                OWN_W          = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*RATIO_W-1:0]   req_ratio,
  input  logic [N_REQ*DELAY_W-1:0]   req_delay,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           err,
  output logic [RATIO_W-1:0]         div_ratio,
  output logic [DELAY_W-1:0]         div_delay,
  output logic                       div_delay_valid,
  input  logic                       dec_clk,
  output logic [OWN_W-1:0]           owner,
  output logic                       busy
);
  localparam int TO_W = $clog2(SETTLE_TIMEOUT + 1);

  state_t                state, state_nxt;
  logic [N_REQ-1:0]      grant;
  logic [OWN_W-1:0]      grant_idx;
  logic                  any_req, accept, reject;
  logic [RATIO_W-1:0]    sel_ratio;
  logic [DELAY_W-1:0]    sel_delay;
  logic [DELAY_W-1:0]    dly_cnt;
  logic [EDGE_CNT_W-1:0] edge_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  dec_clk_q, rise, settle_done, settle_tmo, fail;

  assign accept = (state == IDLE) && any_req;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  always_comb begin
    sel_ratio = '0;
    sel_delay = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_ratio = sel_ratio | req_ratio[i*RATIO_W +: RATIO_W];
        sel_delay = sel_delay | req_delay[i*DELAY_W +: DELAY_W];
      end
    end
  end

`ifdef DEC_SCHED_RANGE_CHECK_EN
  assign reject = (sel_ratio < RATIO_W'(2));
`else
  assign reject = 1'b0;
`endif

  assign rise        = dec_clk & ~dec_clk_q;
  assign settle_done = rise && (edge_cnt == EDGE_CNT_W'(SETTLE_EDGES - 1));
  assign settle_tmo  = (to_cnt == TO_W'(SETTLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_req) state_nxt = reject ? ACK : LOAD;
      LOAD:     state_nxt = WAIT_DLY;
      WAIT_DLY: if (dly_cnt == '0) state_nxt = SETTLE;
      SETTLE:   if (settle_done || settle_tmo) state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner     <= '0;
      div_ratio <= DEFAULT_RATIO;
      div_delay <= '0;
      dly_cnt   <= '0;
      edge_cnt  <= '0;
      to_cnt    <= '0;
      dec_clk_q <= 1'b0;
      fail      <= 1'b0;
    end else begin
      dec_clk_q <= dec_clk;
      if (accept) begin
        owner <= grant_idx;
        fail  <= reject;
        if (!reject) begin
          div_ratio <= sel_ratio;
          div_delay <= sel_delay;
        end
      end
      if (state == LOAD) dly_cnt <= div_delay;
      else if (state == WAIT_DLY && dly_cnt != '0) dly_cnt <= dly_cnt - DELAY_W'(1);
      // An edge arriving in the timeout cycle still counts as a clean settle.
      if (state == SETTLE) begin
        if (rise) edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
        if (to_cnt != TO_W'(SETTLE_TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);
        if (!settle_done && settle_tmo) fail <= 1'b1;
      end else begin
        edge_cnt <= '0;
        to_cnt   <= '0;
      end
    end
  end

  always_comb begin
    ack             = '0;
    err             = '0;
    div_delay_valid = (state == LOAD);
    busy            = (state != IDLE);
    if (state == ACK) begin
      ack[owner] = 1'b1;
      err[owner] = fail;
    end
  end
endmodule

// File: tb/tb_dec_clk_scheduler.sv
// Randomized bench for dec_clk_scheduler against a transaction-timeline reference model.
module tb_dec_clk_scheduler;
  localparam int N_REQ          = 4;
  localparam int SETTLE_EDGES   = 2;
  localparam int SETTLE_TIMEOUT = 1023;
  localparam int OW             = $clog2(N_REQ);

  logic             clk = 1'b0, rst = 1'b0, dec_clk = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ*7-1:0] req_ratio = '0, req_delay = '0;
  logic [N_REQ-1:0] ack, err;
  logic [6:0]       div_ratio, div_delay;
  logic             div_delay_valid, busy;
  logic [OW-1:0]    owner;

  always #5 clk = ~clk;

  dec_clk_scheduler #(.N_REQ(N_REQ), .SETTLE_EDGES(SETTLE_EDGES), .SETTLE_TIMEOUT(SETTLE_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ratio(req_ratio), .req_delay(req_delay),
    .ack(ack), .err(err), .div_ratio(div_ratio), .div_delay(div_delay),
    .div_delay_valid(div_delay_valid), .dec_clk(dec_clk), .owner(owner), .busy(busy)
  );

  int checks = 0, errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: each transaction is a timeline anchored at its grant cycle.
  bit  m_valid = 0, m_active = 0, m_err = 0, m_reject = 0, prev_dclk = 0;
  int  m_ptr = 0, m_owner = 0, m_ratio = 2, m_delay = 0;
  int  m_g = 0, m_s = 0, m_edges = 0, m_ack_at = -1;
  int  cyc = 0, dmode = 1, div_phase = 0, vld_cnt = 0;
  bit  auto_req = 0, hold_all = 0;
  int  ack_log[$];
  bit  err_log[$];

  function automatic void model_update();
    bit rise_now;
    int idx, r, d;
    rise_now = dec_clk && !prev_dclk;
    if (!rst) begin
      m_valid = 1; m_active = 0; m_ptr = 0; m_owner = 0; m_ratio = 2; m_delay = 0; prev_dclk = 0;
      return;
    end
    prev_dclk = dec_clk;
    if (!m_valid) return;
    if (m_active) begin
      if (cyc == m_ack_at) m_active = 0;
      else if (m_ack_at < 0 && cyc >= m_s) begin
        if (rise_now) m_edges++;
        if (m_edges == SETTLE_EDGES) m_ack_at = cyc + 1;
        else if (cyc - m_s + 1 == SETTLE_TIMEOUT) begin m_ack_at = cyc + 1; m_err = 1; end
      end
    end else if (req != 0) begin
      idx = 0;
      for (int k = N_REQ - 1; k >= 0; k--) if (req[(m_ptr + k) % N_REQ]) idx = (m_ptr + k) % N_REQ;
      r = int'(req_ratio[7*idx +: 7]);
      d = int'(req_delay[7*idx +: 7]);
      m_owner = idx; m_ptr = (idx + 1) % N_REQ; m_g = cyc; m_active = 1;
      m_err = 0; m_edges = 0; m_reject = 0;
`ifdef DEC_SCHED_RANGE_CHECK_EN
      if (r < 2) begin m_reject = 1; m_err = 1; m_ack_at = cyc + 1; end
`endif
      if (!m_reject) begin m_ratio = r; m_delay = d; m_s = cyc + 3 + d; m_ack_at = -1; end
    end
  endfunction

  task automatic compare();
    bit is_ack;
    logic [N_REQ-1:0] e_ack, e_err;
    if (div_delay_valid === 1'b1) vld_cnt++;
    if (ack != 0) begin ack_log.push_back(int'(owner)); err_log.push_back(|err); end
    if (!m_valid) return;
    is_ack = m_active && (cyc == m_ack_at);
    e_ack  = is_ack ? N_REQ'(1) << m_owner : '0;
    e_err  = (is_ack && m_err) ? N_REQ'(1) << m_owner : '0;
    check_eq("ack", ack, e_ack);
    check_eq("err", err, e_err);
    check_eq("dly_vld", div_delay_valid, m_active && cyc == m_g + 1 && !m_reject);
    check_eq("busy", busy, m_active);
    check_eq("owner", owner, m_owner);
    check_eq("div_ratio", div_ratio, m_ratio);
    check_eq("div_delay", div_delay, m_delay);
  endtask

  task automatic step();
    int per;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack[i] === 1'b1) req[i] = 1'b0;
      else if (!req[i] && (hold_all || (auto_req && $urandom_range(3) == 0))) begin
        req[i] = 1'b1;
        req_ratio[7*i +: 7] = 7'(hold_all ? $urandom_range(10, 2) : $urandom_range(10));
        req_delay[7*i +: 7] = 7'($urandom_range(4));
      end
    end
    case (dmode)
      0: begin
        if (div_delay_valid === 1'b1) div_phase = 0; else div_phase++;
        per = (div_ratio < 2) ? 2 : int'(div_ratio);
        dec_clk = ((div_phase % per) < per / 2);
      end
      1: dec_clk = 1'b0;
      default: dec_clk = 1'($urandom_range(1));
    endcase
    model_update();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic run_until_ack(input string tag, input int budget);
    int n0, k;
    n0 = ack_log.size();
    k = 0;
    while (ack_log.size() == n0 && k < budget) begin step(); k++; end
    check_eq({tag, "_done"}, ack_log.size() > n0, 1);
  endtask

  task automatic set_req(input int i, input int r, input int d);
    req_ratio[7*i +: 7] = 7'(r);
    req_delay[7*i +: 7] = 7'(d);
    req[i] = 1'b1;
  endtask

  initial begin
    int n0, k, prev_ratio;
    @(negedge clk);
    // Reset held for three cycles, then idle.
    rst = 1'b0;
    repeat (3) step();
    check_eq("rst_ratio", div_ratio, 2);
    rst = 1'b1;
    vld_cnt = 0;
    repeat (3) step();
    check_eq("idle_no_vld", vld_cnt, 0);

    // Single request with a divider model.
    dmode = 0; vld_cnt = 0;
    set_req(2, 4, 3);
    run_until_ack("req2", 200);
    check_eq("req2_owner", ack_log[$], 2);
    check_eq("req2_err", err_log[$], 0);
    check_eq("req2_vld_pulses", vld_cnt, 1);
    repeat (3) step();

    // All requesters held: round-robin order from a fresh pointer.
    rst = 1'b0; step(); rst = 1'b1;
    dmode = 2; hold_all = 1; ack_log.delete(); err_log.delete();
    k = 0;
    while (ack_log.size() < 5 && k < 2000) begin step(); k++; end
    hold_all = 0;
    check_eq("rr_count", ack_log.size(), 5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++) check_eq("rr_order", ack_log[i], i % N_REQ);
    k = 0;
    while ((req != 0 || busy) && k < 3000) begin step(); k++; end
    check_eq("rr_drain", (req == 0 && !busy), 1);

    // Ratio 0 from requester 1.
    dmode = 0; vld_cnt = 0; prev_ratio = int'(div_ratio);
    set_req(1, 0, 1);
    run_until_ack("ratio0", 300);
    check_eq("ratio0_owner", ack_log[$], 1);
`ifdef DEC_SCHED_RANGE_CHECK_EN
    check_eq("ratio0_err", err_log[$], 1);
    check_eq("ratio0_vld", vld_cnt, 0);
    check_eq("ratio0_hold", div_ratio, prev_ratio);
`else
    check_eq("ratio0_err", err_log[$], 0);
    check_eq("ratio0_fwd", div_ratio, 0);
`endif
    repeat (2) step();

    // dec_clk stuck low: forced ack with error.
    dmode = 1;
    set_req(0, 3, 2);
    run_until_ack("tmo", SETTLE_TIMEOUT + 50);
    check_eq("tmo_owner", ack_log[$], 0);
    check_eq("tmo_err", err_log[$], 1);
    repeat (2) step();

    // Reset during WAIT_DLY: aborted, then re-served after release.
    dmode = 0;
    set_req(3, 5, 20);
    repeat (4) step();
    n0 = ack_log.size();
    rst = 1'b0; step(); rst = 1'b1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_noack", ack_log.size(), n0);
    run_until_ack("rst_reserve", 300);
    check_eq("rst_reserve_owner", ack_log[$], 3);

    // Random traffic with random dec_clk.
    dmode = 2; auto_req = 1;
    repeat (800) step();
    auto_req = 0;
    k = 0;
    while ((req != 0 || busy) && k < 3000) begin step(); k++; end
    check_eq("rand_drain", (req == 0 && !busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
